// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - RV32I subset encodings, ALU codes, FSM state and decode helper for mc_ctrl
package mc_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {K_ALU, K_LW, K_SW, K_BEQ} kind_t;

  typedef struct packed {
    logic       legal;
    kind_t      kind;
    logic [3:0] alu;
    logic [1:0] src;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    dec_t d;
    d = '{1'b0, K_ALU, ALU_AND, SRC_REG};
    case (opc)
      OPC_RTYPE: begin
        if (f3 == F3_ADD_SUB && f7 == F7_BASE)   d = '{1'b1, K_ALU, ALU_ADD, SRC_REG};
        else if (f3 == F3_ADD_SUB && f7 == F7_SUB) d = '{1'b1, K_ALU, ALU_SUB, SRC_REG};
        else if (f3 == F3_AND && f7 == F7_BASE)  d = '{1'b1, K_ALU, ALU_AND, SRC_REG};
        else if (f3 == F3_OR && f7 == F7_BASE)   d = '{1'b1, K_ALU, ALU_OR, SRC_REG};
      end
      OPC_OPIMM:  if (f3 == F3_ADDI) d = '{1'b1, K_ALU, ALU_ADD, SRC_IMM};
      OPC_LOAD:   if (f3 == F3_LW)   d = '{1'b1, K_LW, ALU_ADD, SRC_IMM};
      OPC_STORE:  if (f3 == F3_SW)   d = '{1'b1, K_SW, ALU_ADD, SRC_IMM};
      OPC_BRANCH: if (f3 == F3_BEQ)  d = '{1'b1, K_BEQ, ALU_SUB, SRC_REG};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_ctrl_imm_gen.sv
// rtl/mc_ctrl_imm_gen.sv - combinational immediate extraction for I, S and B formats
module imm_gen
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm32
);

  // rs1/funct3 never contribute to an immediate
  logic w_unused;
  assign w_unused = ^i_instr[19:12];

  always_comb begin
    case (i_instr[6:0])
      OPC_OPIMM, OPC_LOAD: o_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:           o_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:          o_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                      i_instr[30:25], i_instr[11:8], 1'b0};
      default:             o_imm32 = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I subset controller; MC_CTRL_ILLEGAL_TRAP_EN selects trap-on-illegal
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ack,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ALUSrc,
  output logic [31:0] imm32,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal
);

  state_t      r_state, w_next;
  logic [31:0] r_instr;
  logic [31:0] w_imm32;
  logic [3:0]  r_alu_ctrl;
  logic [1:0]  r_alu_src;
  logic [31:0] r_imm32;
  dec_t        w_dec;

  assign w_dec = decode(r_instr[6:0], r_instr[14:12], r_instr[31:25]);

  imm_gen u_imm_gen (
    .i_instr (r_instr),
    .o_imm32 (w_imm32)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_alu_ctrl <= '0;
      r_alu_src  <= '0;
      r_imm32    <= '0;
    end else begin
      if (r_state == ST_IDLE && instr_valid) r_instr <= instr;
      if (r_state == ST_DECODE) begin
        r_alu_ctrl <= w_dec.alu;
        r_alu_src  <= w_dec.src;
        r_imm32    <= w_imm32;
      end
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_illegal <= 1'b0;
    else if (r_state == ST_DECODE && !w_dec.legal) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (instr_valid) w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_dec.legal) w_next = ST_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        else             w_next = ST_TRAP;
`else
        else             w_next = ST_IDLE;
`endif
      end
      ST_EXEC: begin
        case (w_dec.kind)
          K_LW, K_SW: w_next = ST_MEM;
          K_BEQ:      w_next = ST_IDLE;
          default:    w_next = ST_WB;
        endcase
      end
      ST_MEM:    if (mem_ack) w_next = (w_dec.kind == K_LW) ? ST_WB : ST_IDLE;
      ST_WB:     w_next = ST_IDLE;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:   w_next = ST_TRAP;
`endif
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from state so an async reset drops them immediately
  always_comb begin
    instr_ready  = (r_state == ST_IDLE);
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    case (r_state)
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      ST_DECODE: done = !w_dec.legal;
`endif
      ST_EXEC: begin
        if (w_dec.kind == K_BEQ) begin
          done         = 1'b1;
          branch_taken = zero;
        end
      end
      ST_MEM: begin
        MemRead  = (w_dec.kind == K_LW);
        MemWrite = (w_dec.kind == K_SW);
        done     = (w_dec.kind == K_SW) && mem_ack;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (w_dec.kind == K_LW);
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl = r_alu_ctrl;
  assign ALUSrc     = r_alu_src;
  assign imm32      = r_imm32;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - table-driven directed bench for mc_ctrl (honours MC_CTRL_ILLEGAL_TRAP_EN)
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ack;
  logic [3:0]  ALUControl;
  logic [1:0]  ALUSrc;
  logic [31:0] imm32;
  logic        RegWrite, MemRead, MemWrite, MemtoReg;
  logic        branch_taken, done, illegal;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .zero         (zero),
    .mem_ack      (mem_ack),
    .ALUControl   (ALUControl),
    .ALUSrc       (ALUSrc),
    .imm32        (imm32),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .branch_taken (branch_taken),
    .done         (done),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        noise;
    int          ack_dly;
    logic        chk_alu;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [31:0] imm;
    int          lat;
    int          rw;
    logic        m2r;
    int          br;
    int          rd;
    int          wr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int lat, memcyc, rd, wr, rw, brc, rdy_bad, n, dn;
    logic got, m2r;

    //           instr         z  nz dly chk alu      src    imm           lat rw m2r br rd wr
    vecs.push_back('{32'h002081B3, 0, 0, 0, 1, 4'b0010, 2'b00, 32'h00000000, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{32'h402081B3, 0, 0, 0, 1, 4'b0110, 2'b00, 32'h00000000, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{32'h0020F1B3, 0, 0, 0, 1, 4'b0000, 2'b00, 32'h00000000, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{32'h0020E1B3, 0, 0, 0, 1, 4'b0001, 2'b00, 32'h00000000, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{32'hFFF00093, 0, 0, 0, 1, 4'b0010, 2'b01, 32'hFFFFFFFF, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{32'h00812283, 0, 0, 3, 1, 4'b0010, 2'b01, 32'h00000008, 6, 1, 1, 0, 3, 0});
    vecs.push_back('{32'h00812283, 0, 1, 1, 1, 4'b0010, 2'b01, 32'h00000008, 4, 1, 1, 0, 1, 0});
    vecs.push_back('{32'h00512623, 0, 0, 2, 1, 4'b0010, 2'b01, 32'h0000000C, 4, 0, 0, 0, 0, 2});
    vecs.push_back('{32'hFE512E23, 0, 1, 1, 1, 4'b0010, 2'b01, 32'hFFFFFFFC, 3, 0, 0, 0, 0, 1});
    vecs.push_back('{32'hFE208EE3, 1, 0, 0, 1, 4'b0110, 2'b00, 32'hFFFFFFFC, 2, 0, 0, 1, 0, 0});
    vecs.push_back('{32'hFE208EE3, 0, 1, 0, 1, 4'b0110, 2'b00, 32'hFFFFFFFC, 2, 0, 0, 0, 0, 0});
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    vecs.push_back('{32'hFFFFFFFF, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00000000, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{32'h022081B3, 0, 0, 0, 0, 4'b0000, 2'b00, 32'h00000000, 1, 0, 0, 0, 0, 0});
`endif

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset instr_ready", instr_ready, 1);
    check("reset ALUControl", ALUControl, 0);
    check("reset ALUSrc", ALUSrc, 0);
    check("reset imm32", imm32, 0);
    check("reset strobes", {RegWrite, MemRead, MemWrite, MemtoReg, branch_taken, done, illegal}, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      instr = v.instr; instr_valid = 1'b1; zero = v.zero; mem_ack = v.noise;
      #1 check($sformatf("v%0d ready before", i), instr_ready, 1);
      @(posedge clk);
      lat = 0; memcyc = 0; rd = 0; wr = 0; rw = 0; brc = 0; rdy_bad = 0; got = 1'b0; m2r = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        lat++;
        if (MemRead || MemWrite) begin
          memcyc++;
          mem_ack = (memcyc == v.ack_dly);
        end else begin
          mem_ack = v.noise;
        end
        #1;
        rd += int'(MemRead); wr += int'(MemWrite); rw += int'(RegWrite); brc += int'(branch_taken);
        if (instr_ready) rdy_bad++;
        if (done) begin
          got = 1'b1;
          m2r = MemtoReg;
        end
      end
      instr_valid = 1'b0;
      @(negedge clk);
      mem_ack = 1'b0; zero = 1'b0;
      #1;
      check($sformatf("v%0d latency", i), lat, v.lat);
      check($sformatf("v%0d RegWrite cycles", i), rw, v.rw);
      check($sformatf("v%0d MemtoReg at done", i), m2r, v.m2r);
      check($sformatf("v%0d branch_taken cycles", i), brc, v.br);
      check($sformatf("v%0d MemRead cycles", i), rd, v.rd);
      check($sformatf("v%0d MemWrite cycles", i), wr, v.wr);
      check($sformatf("v%0d ready while busy", i), rdy_bad, 0);
      check($sformatf("v%0d ready after done", i), instr_ready, 1);
      check($sformatf("v%0d done after retire", i), done, 0);
      if (v.chk_alu) begin
        check($sformatf("v%0d ALUControl", i), ALUControl, v.alu);
        check($sformatf("v%0d ALUSrc", i), ALUSrc, v.src);
        check($sformatf("v%0d imm32", i), imm32, v.imm);
      end
    end

    // sw caught in MEM by an asynchronous reset
    @(negedge clk);
    instr = 32'h00512623; instr_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    while (!MemWrite && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst sw reached MEM", MemWrite, 1);
    check("rst ALUControl before", ALUControl, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("rst MemWrite async drop", MemWrite, 0);
    check("rst instr_ready async", instr_ready, 1);
    check("rst ALUControl async", ALUControl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst release instr_ready", instr_ready, 1);
    check("rst release ALUControl", ALUControl, 0);
    check("rst release strobes", {RegWrite, MemRead, MemWrite, done}, 0);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    @(negedge clk);
    instr = 32'hFFFFFFFF; instr_valid = 1'b1;
    @(posedge clk);
    dn = 0; n = 0;
    repeat (6) begin
      @(negedge clk);
      dn += int'(done) + int'(RegWrite) + int'(MemRead) + int'(MemWrite);
      if (n >= 1 && instr_ready) rdy_bad++;
      n++;
    end
    check("trap illegal set", illegal, 1);
    check("trap instr_ready stuck low", instr_ready, 0);
    check("trap no done or strobes", dn, 0);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("trap reset clears illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("trap reset ready", instr_ready, 1);
`else
    dn = 0;
    check("no-trap illegal tied low", illegal, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instr_valid  in  1  instruction word offered.
REQ-005 instr_ready  out  1  controller can accept an instruction; high only in IDLE.
REQ-006 instr  in  32  RV32I instruction word, sampled on the handshake.
REQ-007 zero  in  1  ALU zero flag, sampled in EXEC.
REQ-008 mem_ack  in  1  data memory completed the current access.
REQ-009 ALUControl  out  4  ALU op: 0010 add, 0110 sub, 0000 and, 0001 or.
REQ-010 ALUSrc  out  2  ALU operand-2 select: 00 register, 01 imm32.
REQ-011 imm32  out  32  sign-extended immediate of the current instruction.
REQ-012 RegWrite, MemRead, MemWrite, MemtoReg  out  1 each  datapath strobes.
REQ-013 branch_taken  out  1  one-cycle pulse: the beq condition held.
REQ-014 done  out  1  one-cycle pulse: the instruction retired.
REQ-015 illegal  out  1  sticky flag: unsupported instruction seen (only when the macro in REQ-031 is defined).

Function
REQ-016 FSM states SHALL be IDLE, DECODE, EXEC, MEM, WB, plus TRAP when the macro in REQ-031 is defined.
REQ-017 IDLE: instr_ready=1; when instr_valid=1, latch instr into the instruction register and go to DECODE.
REQ-018 DECODE (1 cycle): register ALUControl, ALUSrc and imm32; hold all three unchanged until the next DECODE.
REQ-019 Supported instructions and their decode:
  - add (f7=0000000) -> 0010/00; sub (f7=0100000) -> 0110/00.
  - and (f3=111) -> 0000/00; or (f3=110) -> 0001/00.
  - addi (0010011, f3=000), lw (0000011, f3=010), sw (0100011, f3=010) -> 0010/01.
  - beq (1100011, f3=000) -> 0110/00.
REQ-020 imm32 formats:
  - I-type: sign-extended instr[31:20].
  - S-type: sign-extended {instr[31:25], instr[11:7]}.
  - B-type: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R-type: imm32=0.
REQ-021 EXEC (1 cycle): R-type and addi go to WB; lw and sw go to MEM; beq pulses branch_taken if zero=1, pulses done, then returns to IDLE.
REQ-022 MEM: hold MemRead (lw) or MemWrite (sw) high until the cycle in which mem_ack=1.
  - lw then goes to WB.
  - sw pulses done and returns to IDLE.
  - There is no timeout.
REQ-023 WB (1 cycle): RegWrite=1; MemtoReg=1 for lw only; pulse done; return to IDLE.
REQ-024 Latency from the handshake cycle to done: R-type/addi 3 cycles; beq 2 cycles; lw/sw 2 + (cycles in MEM) (+1 for lw).
REQ-025 mem_ack outside MEM SHALL be ignored; instr_valid outside IDLE SHALL be ignored and instr_ready SHALL stay 0.
REQ-026 An unsupported opcode/funct combination SHALL never assert RegWrite, MemRead or MemWrite.

Reset
REQ-027 rst_n low SHALL immediately force IDLE; this applies mid-instruction and drops any MEM access in progress.
REQ-028 Reset values SHALL be: ALUControl=0000, ALUSrc=00, imm32=0, instruction register=0, all strobes=0, done=0, branch_taken=0, illegal=0.
REQ-029 instr_ready=1 from the first cycle after reset release.

Configuration
REQ-030 Exactly one compile-time option SHALL exist, selected by the macro in REQ-031.
REQ-031 MC_CTRL_ILLEGAL_TRAP_EN defined: an unsupported instruction in DECODE goes to TRAP and sets illegal.
  - TRAP: instr_ready=0; stay until reset.
  - illegal stays set until reset.
REQ-032 MC_CTRL_ILLEGAL_TRAP_EN undefined: an unsupported instruction is a NOP.
  - DECODE goes to IDLE and pulses done.
  - The illegal port is tied to 0.

Structure
REQ-033 Package mc_ctrl_pkg SHALL hold: opcode/funct3/funct7 constants, the ALUControl code constants, ALUSrc codes, and the FSM state typedef.
REQ-034 Sub-module imm_gen SHALL be combinational: instr -> imm32 per REQ-020; its output is registered by mc_ctrl in DECODE.

Verification
REQ-035 add x3,x1,x2 (0x002081B3):
  - DECODE gives ALUControl=0010, ALUSrc=00.
  - RegWrite=1 exactly 3 cycles after the handshake, with done in the same cycle.
REQ-036 addi x1,x0,-1 (0xFFF00093): imm32=0xFFFFFFFF, ALUSrc=01, ALUControl=0010, RegWrite in WB.
REQ-037 lw x5,8(x2) (0x00812283) with mem_ack delayed 3 cycles:
  - MemRead is held for 3 cycles.
  - Then WB with RegWrite=1, MemtoReg=1.
  - imm32=8.
REQ-038 beq x1,x2,-4 (0xFE208EE3):
  - imm32=0xFFFFFFFC, ALUControl=0110.
  - zero=1 in EXEC -> branch_taken=1 and done=1 in that cycle.
  - zero=0 -> branch_taken=0, done=1.
REQ-039 sw in MEM with rst_n pulsed low:
  - MemWrite drops asynchronously and the FSM is in IDLE.
  - ALUControl=0000 and instr_ready=1 after release.
REQ-040 Illegal word 0xFFFFFFFF:
  - With MC_CTRL_ILLEGAL_TRAP_EN: illegal=1 and instr_ready stuck at 0 until reset.
  - Without it: done pulses, no strobes assert, and instr_ready=1 again 2 cycles after the handshake.
